// File: rtl/ps2_kbd_ctrl.sv
// Sequencer that drains scan codes from the ps2_keyboard FIFO and tracks the held key.
// Handles F0 (break) and E0 (extended) prefixes, counts distinct presses and latches overflow.
module ps2_kbd_ctrl #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             code_valid,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_SETTLE, S_PROC} state_t;

    state_t           state, state_nx;
    logic [7:0]       code_r, code_nx;
    logic [2:0]       settle_cnt, settle_nx;
    logic             break_pend, break_nx;
    logic             ext_pend, ext_nx;
    logic             nextdata_nx;
    logic [7:0]       cur_code_nx;
    logic             cur_ext_nx;
    logic             key_down_nx;
    logic [CNT_W-1:0] press_cnt_nx;
    logic             code_valid_nx;
    logic             ovf_nx;
    logic             same_key;

    assign same_key = key_down && ({ext_pend, code_r} == {cur_ext, cur_code});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            code_r         <= 8'h00;
            settle_cnt     <= 3'd0;
            break_pend     <= 1'b0;
            ext_pend       <= 1'b0;
            kbd_nextdata_n <= 1'b1;
            cur_code       <= 8'h00;
            cur_ext        <= 1'b0;
            key_down       <= 1'b0;
            press_cnt      <= '0;
            code_valid     <= 1'b0;
            ovf_sticky     <= 1'b0;
        end else begin
            state          <= state_nx;
            code_r         <= code_nx;
            settle_cnt     <= settle_nx;
            break_pend     <= break_nx;
            ext_pend       <= ext_nx;
            kbd_nextdata_n <= nextdata_nx;
            cur_code       <= cur_code_nx;
            cur_ext        <= cur_ext_nx;
            key_down       <= key_down_nx;
            press_cnt      <= press_cnt_nx;
            code_valid     <= code_valid_nx;
            ovf_sticky     <= ovf_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        code_nx       = code_r;
        settle_nx     = settle_cnt;
        break_nx      = break_pend;
        ext_nx        = ext_pend;
        nextdata_nx   = 1'b1;
        cur_code_nx   = cur_code;
        cur_ext_nx    = cur_ext;
        key_down_nx   = key_down;
        press_cnt_nx  = press_cnt;
        code_valid_nx = 1'b0;
        ovf_nx        = ovf_sticky | kbd_overflow;

        case (state)
            S_IDLE: begin
                if (kbd_ready) begin
                    code_nx     = kbd_data;
                    nextdata_nx = 1'b0;
                    state_nx    = S_POP;
                end
            end
            S_POP: begin
                settle_nx = 3'(SETTLE);
                state_nx  = S_SETTLE;
            end
            // Spend SETTLE cycles here so the FIFO head has moved before ready is looked at again
            S_SETTLE: begin
                settle_nx = settle_cnt - 3'd1;
                if (settle_cnt <= 3'd1) begin
                    state_nx = S_PROC;
                end
            end
            S_PROC: begin
                state_nx = S_IDLE;
                if (code_r == 8'hF0) begin
                    break_nx = 1'b1;
                end else if (code_r == 8'hE0) begin
                    ext_nx = 1'b1;
                end else if (break_pend) begin
                    // Releases of keys other than the tracked one are dropped
                    if (same_key) begin
                        key_down_nx = 1'b0;
                    end
                    break_nx      = 1'b0;
                    ext_nx        = 1'b0;
                    code_valid_nx = 1'b1;
                end else if (same_key) begin
                    ext_nx        = 1'b0;
                    code_valid_nx = 1'b1;
                end else begin
                    cur_code_nx   = code_r;
                    cur_ext_nx    = ext_pend;
                    key_down_nx   = 1'b1;
                    press_cnt_nx  = press_cnt + 1'b1;
                    ext_nx        = 1'b0;
                    code_valid_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a FIFO model feeds directed scan codes, a monitor
// checks each code_valid pulse against hand-computed expectations.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic [7:0] cur_code;
    logic       cur_ext;
    logic       key_down;
    logic [7:0] press_cnt;
    logic       code_valid;
    logic       ovf_sticky;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic [7:0] cnt;
    } exp_t;

    logic [7:0] fifo[$];
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;

    ps2_kbd_ctrl #(.CNT_W(8), .SETTLE(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kbd_data(kbd_data),
        .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow),
        .kbd_nextdata_n(kbd_nextdata_n),
        .cur_code(cur_code),
        .cur_ext(cur_ext),
        .key_down(key_down),
        .press_cnt(press_cnt),
        .code_valid(code_valid),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver FIFO model: pop on a low strobe, then present the new head
    always @(negedge clk) begin
        if (!kbd_nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
        kbd_ready = (fifo.size() > 0);
        kbd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (rst_n && code_valid) begin
            exp_t e;
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_code_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("cur_code", 32'(cur_code), 32'(e.code));
                checkOutput("cur_ext", 32'(cur_ext), 32'(e.ext));
                checkOutput("key_down", 32'(key_down), 32'(e.down));
                checkOutput("press_cnt", 32'(press_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic sendPrefix(input logic [7:0] code);
        fifo.push_back(code);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic [7:0] e_code,
                                 input logic e_ext, input logic e_down, input logic [7:0] e_cnt);
        exp_t e;
        e.code = e_code;
        e.ext  = e_ext;
        e.down = e_down;
        e.cnt  = e_cnt;
        fifo.push_back(code);
        exp_q.push_back(e);
    endtask

    task automatic drainFifo(input int limit);
        int n = 0;
        while (fifo.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput("drain_timeout", 32'd1, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_nextdata_n"}, 32'(kbd_nextdata_n), 32'd1);
        checkOutput({tag, "_outputs"},
                    32'({cur_code, cur_ext, key_down, press_cnt, code_valid, ovf_sticky}), 32'd0);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // make, break of the same key
        base = valid_cnt;
        @(posedge clk); #1;
        applyStimulus(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1);
        sendPrefix(8'hF0);
        applyStimulus(8'h1C, 8'h1C, 1'b0, 1'b0, 8'd1);
        drainFifo(200);
        checkOutput("pulses_seq1", 32'(valid_cnt - base), 32'd2);

        // typematic repeats count once
        base = valid_cnt;
        @(posedge clk); #1;
        applyStimulus(8'h1B, 8'h1B, 1'b0, 1'b1, 8'd2);
        applyStimulus(8'h1B, 8'h1B, 1'b0, 1'b1, 8'd2);
        applyStimulus(8'h1B, 8'h1B, 1'b0, 1'b1, 8'd2);
        sendPrefix(8'hF0);
        applyStimulus(8'h1B, 8'h1B, 1'b0, 1'b0, 8'd2);
        drainFifo(200);
        checkOutput("pulses_seq2", 32'(valid_cnt - base), 32'd4);

        // cycle-exact handshake for a single code
        @(posedge clk); #1;
        applyStimulus(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd3);
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hs_nextdata_n_c%0d", k), 32'(kbd_nextdata_n), (k == 1) ? 32'd0 : 32'd1);
            checkOutput($sformatf("hs_code_valid_c%0d", k), 32'(code_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        sendPrefix(8'hF0);
        applyStimulus(8'h1C, 8'h1C, 1'b0, 1'b0, 8'd3);
        drainFifo(200);

        // break of a non-tracked key is ignored
        @(posedge clk); #1;
        applyStimulus(8'h1B, 8'h1B, 1'b0, 1'b1, 8'd4);
        sendPrefix(8'hF0);
        applyStimulus(8'h1C, 8'h1B, 1'b0, 1'b1, 8'd4);
        applyStimulus(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd5);
        drainFifo(200);

        // extended key make/break, then plain key with same code
        @(posedge clk); #1;
        sendPrefix(8'hE0);
        applyStimulus(8'h75, 8'h75, 1'b1, 1'b1, 8'd6);
        sendPrefix(8'hE0);
        sendPrefix(8'hF0);
        applyStimulus(8'h75, 8'h75, 1'b1, 1'b0, 8'd6);
        applyStimulus(8'h75, 8'h75, 1'b0, 1'b1, 8'd7);
        sendPrefix(8'hF0);
        applyStimulus(8'h75, 8'h75, 1'b0, 1'b0, 8'd7);
        drainFifo(300);

        // run the counter up to FF and across the wrap
        @(posedge clk); #1;
        for (int i = 0; i < 248; i++) begin
            logic [7:0] c;
            c = (i % 2 == 1) ? 8'h11 : 8'h10;
            applyStimulus(c, c, 1'b0, 1'b1, 8'(8 + i));
        end
        drainFifo(2000);
        checkOutput("cnt_at_ff", 32'(press_cnt), 32'hFF);
        @(posedge clk); #1;
        applyStimulus(8'h10, 8'h10, 1'b0, 1'b1, 8'h00);
        drainFifo(200);

        // overflow latches until reset
        checkOutput("ovf_before", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;
        kbd_overflow = 1'b1;
        @(posedge clk); #1;
        kbd_overflow = 1'b0;
        checkOutput("ovf_set", 32'(ovf_sticky), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("ovf_held", 32'(ovf_sticky), 32'd1);

        // leave break/ext pending, then reset in the middle of the next code's settle
        @(posedge clk); #1;
        sendPrefix(8'hF0);
        sendPrefix(8'hE0);
        drainFifo(200);
        base = valid_cnt;
        @(posedge clk); #1;
        sendPrefix(8'h2A);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        checkResetOutputs("midreset_hold");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no_stale_code", 32'(valid_cnt - base), 32'd0);
        checkOutput("after_reset_outputs",
                    32'({cur_code, key_down, press_cnt, ovf_sticky}), 32'd0);
        @(posedge clk); #1;
        applyStimulus(8'h2A, 8'h2A, 1'b0, 1'b1, 8'd1);
        drainFifo(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencer that sits between the ps2_keyboard receiver and the display/state logic.
- Drains scan codes from the receiver's FIFO using its ready/nextdata_n handshake.
- Interprets make, break (F0) and extended (E0) prefixes and tracks the currently held key.
- Counts distinct key presses, ignoring typematic repeats, and reports receiver overflow.

Parameters:
- CNT_W, 8, width of the press counter.
- SETTLE, 1, idle cycles after a pop before ready is sampled again (range 1..7).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- kbd_data  input  8  scan code at FIFO head (ps2_keyboard data).
- kbd_ready  input  1  FIFO non-empty (ps2_keyboard ready).
- kbd_overflow  input  1  FIFO overflow flag (ps2_keyboard overflow).
- kbd_nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
- cur_code  output  8  scan code of the held / last pressed key.
- cur_ext  output  1  cur_code was E0-prefixed.
- key_down  output  1  a key is currently held.
- press_cnt  output  CNT_W  count of distinct presses; wraps modulo 2^CNT_W.
- code_valid  output  1  one-cycle pulse when a non-prefix code is processed.
- ovf_sticky  output  1  latched kbd_overflow; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0) forces:
  - kbd_nextdata_n=1.
  - cur_code=0, cur_ext=0, key_down=0, press_cnt=0, code_valid=0, ovf_sticky=0.
  - Internal break_pend=0, ext_pend=0, state=IDLE.
  - Reset mid-sequence discards any latched code and pending prefixes; no partial update survives.
- FSM states: IDLE, POP, SETTLE, PROC.
- IDLE:
  - If kbd_ready=1, latch kbd_data into code_r, drive kbd_nextdata_n=0 and go to POP.
  - Otherwise stay in IDLE.
  - kbd_nextdata_n=0 for exactly one clock per code.
- POP: kbd_nextdata_n returns to 1; load settle counter with SETTLE; go to SETTLE.
- SETTLE:
  - Count down; kbd_ready is ignored here.
  - At zero go to PROC. This guarantees the FIFO read pointer has advanced.
- PROC: single cycle, then IDLE. Decode code_r, first matching rule wins:
  - code_r=F0: break_pend=1; no output change.
  - code_r=E0: ext_pend=1; no output change.
  - Break (break_pend=1):
    - If key_down=1 and {ext_pend,code_r}=={cur_ext,cur_code}, then key_down=0.
    - Otherwise ignore the break (release of a non-tracked key).
    - Clear break_pend and ext_pend; pulse code_valid.
  - Typematic repeat (break_pend=0, key_down=1, {ext_pend,code_r}=={cur_ext,cur_code}): press_cnt unchanged; clear ext_pend; pulse code_valid.
  - Otherwise (new make):
    - cur_code=code_r, cur_ext=ext_pend, key_down=1, press_cnt=press_cnt+1 (wraps to 0 from all-ones).
    - Clear ext_pend; pulse code_valid.
- Worst-case latency from kbd_ready rising (while in IDLE) to code_valid: 3+SETTLE clocks. Default SETTLE=1 gives 4 clocks.
- Back-to-back codes: each code costs 3+SETTLE clocks; FIFO overflow is the receiver's concern.
- ovf_sticky is set on any cycle with kbd_overflow=1, in any state.
- F0 F0: second F0 simply keeps break_pend=1.
- E0 followed by F0: both flags held until the next non-prefix code.

Test Plan:
- Reset, then send 1C, F0, 1C:
  - After 1C: key_down=1, cur_code=1C, press_cnt=1.
  - After the break: key_down=0, press_cnt=1, code_valid pulsed twice in total.
- Send 1B, 1B, 1B, F0, 1B:
  - press_cnt increments once only (1 to 2 after the prior test); code_valid pulses 4 times.
  - key_down=0 at end; cur_code=1B.
- Handshake check, single code 1C:
  - kbd_nextdata_n is low exactly 1 cycle, on the cycle after ready is sampled in IDLE.
  - code_valid appears 4 clocks after kbd_ready rises (SETTLE=1).
  - No second pop while the FIFO is empty.
- Hold 1B, then send F0 1C:
  - key_down stays 1 and cur_code stays 1B.
  - Next 1C make gives cur_code=1C and press_cnt+1.
- Send E0 75, then E0 F0 75:
  - After E0 75: cur_ext=1, cur_code=75, key_down=1.
  - After the break: key_down=0.
  - A plain 75 afterwards counts as a new press (cur_ext=0).
- Preload press_cnt=FF via presses; pulse kbd_overflow; assert rst_n=0 mid-SETTLE:
  - Counter wraps FF to 00.
  - ovf_sticky=1 until reset.
  - During reset all outputs are 0, kbd_nextdata_n=1, and state=IDLE.
